// File: rtl/line_io_pkg.sv
// Shared constants, FSM state type and word framing for the line result drain.
// RESULT_PARITY_EN adds one even-parity beat after each result word.
package line_io_pkg;

    localparam int WORD_W = 25;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

`ifdef RESULT_PARITY_EN
    localparam int BEATS = WORD_W + 1;
`else
    localparam int BEATS = WORD_W;
`endif

    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LOAD,
        SHIFT,
        FIN
    } state_t;

    // Beat image of one word, MSB first; parity (if any) is the final beat.
    function automatic logic [BEATS-1:0] frame_word(
        input logic [WORD_W-1:0] w
    );
`ifdef RESULT_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/line_shift_out.sv
// Serialiser for one result word: load register, beat counter, eow/last flags.
// Ports: clear/load/word/last_word in, ser_ready in; ser_valid/bit/eow/last, done out.
module line_shift_out
    import line_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              last_word,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic              ser_eow,
    output logic              ser_last,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

    logic [BEATS-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             last_q;
    logic             final_beat;

    assign final_beat = (cnt == CNT_MAX);

    // Outputs are gated by valid so the idle line always reads 0.
    assign ser_bit  = ser_valid & sreg[BEATS-1];
    assign ser_eow  = ser_valid & final_beat;
    assign ser_last = ser_eow & last_q;
    assign done     = ser_valid & ser_ready & final_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_valid <= 1'b0;
            sreg      <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
        end else if (clear) begin
            ser_valid <= 1'b0;
            cnt       <= '0;
            last_q    <= 1'b0;
        end else if (load) begin
            ser_valid <= 1'b1;
            sreg      <= frame_word(word);
            cnt       <= '0;
            last_q    <= last_word;
        end else if (ser_valid && ser_ready) begin
            if (final_beat) begin
                ser_valid <= 1'b0;
            end else begin
                sreg <= {sreg[BEATS-2:0], 1'b0};
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_result_drain.sv
// Captures one result word per line into a 64-entry buffer, then streams it
// out MSB-first, bit-serially under valid/ready. Optional: RESULT_PARITY_EN.
// Ports: start/line_done/line_idx/res_word/flush in; ser_* stream, busy/full/overrun out.
module line_result_drain
    import line_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              line_done,
    input  logic [ADDR_W-1:0] line_idx,
    input  logic [WORD_W-1:0] res_word,
    input  logic              flush,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic              ser_eow,
    output logic              ser_last,
    output logic              busy,
    output logic              full,
    output logic              overrun
);

    state_t            state;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  bitmap;
    logic [ADDR_W-1:0] rd_ptr;
    logic [WORD_W-1:0] rd_word;
    logic              capture;
    logic              load;
    logic              word_done;
    logic              at_end;

    assign capture = line_done && !start && (state == COLLECT);
    assign load    = !start && (state == LOAD);
    assign at_end  = (rd_ptr == ADDR_W'(DEPTH - 1));
    assign busy    = (state == LOAD) || (state == SHIFT);

    // Lines never written this image read back as zero.
    assign rd_word = bitmap[rd_ptr] ? mem[rd_ptr] : '0;

    // Buffer contents need no reset; the bitmap qualifies them.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[line_idx] <= res_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bitmap  <= '0;
            rd_ptr  <= '0;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else if (start) begin
            state   <= COLLECT;
            bitmap  <= '0;
            rd_ptr  <= '0;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            full <= &bitmap;
            if (line_done && (state != COLLECT)) begin
                overrun <= 1'b1;
            end
            if (capture) begin
                bitmap[line_idx] <= 1'b1;
            end
            unique case (state)
                IDLE, FIN: begin
                    state <= state;
                end
                COLLECT: begin
                    if (full || flush) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    // Terminal compare: the pointer stops at the last line.
                    if (word_done) begin
                        if (at_end) begin
                            state <= FIN;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    line_shift_out u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .load      (load),
        .word      (rd_word),
        .last_word (at_end),
        .ser_ready (ser_ready),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_eow   (ser_eow),
        .ser_last  (ser_last),
        .done      (word_done)
    );

endmodule

// File: tb/tb_line_result_drain.sv
// Directed bench for line_result_drain: capture, flush, back-pressure,
// overrun, reset mid-stream and word framing (parity when RESULT_PARITY_EN).
`timescale 1ns/1ps
module tb_line_result_drain;

    localparam int WW = 25;
    localparam int NW = 64;
`ifdef RESULT_PARITY_EN
    localparam int BW = 26;
`else
    localparam int BW = 25;
`endif
    localparam int NB = NW * BW;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        line_done;
    logic [5:0]  line_idx;
    logic [24:0] res_word;
    logic        flush;
    logic        ser_ready;
    logic        ser_valid;
    logic        ser_bit;
    logic        ser_eow;
    logic        ser_last;
    logic        busy;
    logic        full;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    bit sbits [NB];
    bit ref_bits [NB];
    int nbeat;
    int eow_cnt;
    int eow_bad;
    int first_eow;
    int last_cnt;
    int last_pos;
    int hold_bad;
    int span;

    always #5 clk = ~clk;

    line_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .line_done (line_done),
        .line_idx  (line_idx),
        .res_word  (res_word),
        .flush     (flush),
        .ser_ready (ser_ready),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_eow   (ser_eow),
        .ser_last  (ser_last),
        .busy      (busy),
        .full      (full),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            line_done = 1'b1;
            line_idx  = 6'(i);
            res_word  = 25'(i * 3);
            step();
        end
        line_done = 1'b0;
    endtask

    function automatic logic [24:0] word_at(input int w);
        logic [24:0] v;
        v = '0;
        for (int b = 0; b < WW; b++) begin
            v = {v[23:0], sbits[w * BW + b]};
        end
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {ser_valid, ser_bit, ser_eow, ser_last, busy, full, overrun};
    endfunction

    // Accepts the whole stream; tog alternates ready every cycle.
    task automatic drain(input bit tog);
        bit   r;
        bit   held;
        bit   fin;
        logic hb;
        logic he;
        int   first;
        nbeat = 0; eow_cnt = 0; eow_bad = 0; first_eow = -1;
        last_cnt = 0; last_pos = -1; hold_bad = 0; span = -1;
        r = 1'b1; held = 1'b0; fin = 1'b0; first = -1;
        hb = 1'b0; he = 1'b0;
        for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
            ser_ready = r;
            if (held && (!ser_valid || ser_bit !== hb || ser_eow !== he))
                hold_bad++;
            held = 1'b0;
            if (ser_valid && r) begin
                if (nbeat < NB) sbits[nbeat] = ser_bit;
                if (first < 0) first = cyc;
                if (ser_eow) begin
                    eow_cnt++;
                    if (first_eow < 0) first_eow = nbeat;
                    if ((nbeat % BW) != BW - 1) eow_bad++;
                end else if ((nbeat % BW) == BW - 1) begin
                    eow_bad++;
                end
                if (ser_last) begin
                    last_cnt++;
                    last_pos = nbeat;
                    if (!ser_eow) eow_bad++;
                    fin = 1'b1;
                    span = cyc - first;
                end
                nbeat++;
            end else if (ser_valid) begin
                held = 1'b1;
                hb = ser_bit;
                he = ser_eow;
            end
            step();
            r = tog ? ~r : 1'b1;
        end
        ser_ready = 1'b0;
        if (!fin) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int bad;
        rst = 1'b0; start = 1'b0; line_done = 1'b0; line_idx = '0;
        res_word = '0; flush = 1'b0; ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 0);
        rst = 1'b1;
        step();

        // Full image, ready always high.
        pulse_start();
        fill(NW);
        check("full_at_capture", 32'(full), 0);
        step();
        check("full_next", 32'(full), 1);
        check("busy_collect", 32'(busy), 0);
        step();
        check("load_busy", 32'(busy), 1);
        check("load_valid", 32'(ser_valid), 0);
        step();
        check("first_valid", 32'(ser_valid), 1);
        drain(1'b0);
        check("t2_beats", nbeat, NB);
        check("t2_eow_cnt", eow_cnt, NW);
        check("t2_eow_pos", eow_bad, 0);
        check("t2_last_cnt", last_cnt, 1);
        check("t2_last_pos", last_pos, NB - 1);
        check("t2_span", span, 63 * (BW + 1) + BW - 1);
        check("t2_word5", 32'(word_at(5)), 32'h0000000f);
        bad = 0;
        for (int w = 0; w < NW; w++) begin
            if (word_at(w) !== 25'(w * 3)) bad++;
`ifdef RESULT_PARITY_EN
            if (sbits[w * BW + WW] !== ^(25'(w * 3))) bad++;
`endif
        end
        check("t2_words", bad, 0);
        ref_bits = sbits;
        step();
        check("fin_outs", 32'(outs()), 32'b0000010);

        // Partial image forced out by flush; flush cycle also captures.
        pulse_start();
        line_done = 1'b1; line_idx = 6'd0; res_word = 25'h1abcdef;
        step();
        line_idx = 6'd1; res_word = 25'h0000001; flush = 1'b1;
        step();
        line_done = 1'b0; flush = 1'b0;
        check("t3_full", 32'(full), 0);
        drain(1'b0);
        check("t3_beats", nbeat, NB);
        check("t3_word0", 32'(word_at(0)), 32'h01abcdef);
        check("t3_word1", 32'(word_at(1)), 32'h00000001);
        bad = 0;
        for (int w = 2; w < NW; w++) if (word_at(w) !== 25'd0) bad++;
        check("t3_zero_words", bad, 0);

        // Ready toggling every cycle.
        pulse_start();
        fill(NW);
        drain(1'b1);
        check("t4_beats", nbeat, NB);
        bad = 0;
        for (int i = 0; i < NB; i++) if (sbits[i] !== ref_bits[i]) bad++;
        check("t4_bits", bad, 0);
        check("t4_hold", hold_bad, 0);
        check("t4_span", span, 63 * 2 * BW + 2 * (BW - 1));

        // line_done while shifting is dropped and flagged.
        pulse_start();
        fill(NW);
        ser_ready = 1'b0;
        repeat (3) step();
        check("t5_shift_valid", 32'(ser_valid), 1);
        line_done = 1'b1; line_idx = 6'd5; res_word = 25'h1ffffff;
        step();
        line_done = 1'b0;
        check("t5_overrun", 32'(overrun), 1);
        drain(1'b0);
        check("t5_word5", 32'(word_at(5)), 32'h0000000f);
        check("t5_word6", 32'(word_at(6)), 32'h00000012);
        check("t5_sticky", 32'(overrun), 1);
        pulse_start();
        check("t5_cleared", 32'(overrun), 0);

        // Word framing for a single small word.
        line_done = 1'b1; line_idx = 6'd0; res_word = 25'h0000007;
        flush = 1'b1;
        step();
        line_done = 1'b0; flush = 1'b0;
        drain(1'b0);
        check("t6_word0", 32'(word_at(0)), 32'h00000007);
        check("t6_first_eow", first_eow, BW - 1);
        check("t6_lsb", 32'(sbits[24]), 1);
`ifdef RESULT_PARITY_EN
        check("t6_parity", 32'(sbits[25]), 1);
`endif

        // Reset asserted mid-stream.
        pulse_start();
        fill(NW);
        ser_ready = 1'b1;
        repeat (10) step();
        check("t1_streaming", 32'(ser_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("t1_async_outs", 32'(outs()), 0);
        step();
        check("t1_edge_outs", 32'(outs()), 0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ser_valid || busy) bad++;
        end
        check("t1_idle_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
